// File: rtl/gshare_predictor_pkg.sv
// Shared decode helpers for the gshare branch predictor.
// Holds the control-flow opcodes, J/B immediate extraction and the link-register test.
// Pure types and functions; no state, no handshake.
package gshare_predictor_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Fields of the fetched instruction the predictor cares about.
  typedef struct packed {
    logic       is_br;
    logic       is_jal;
    logic       is_jalr;
    logic [4:0] rd;
    logic [4:0] rs1;
  } dec_t;

  function automatic logic [31:0] j_imm(input logic [31:0] ins);
    return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] b_imm(input logic [31:0] ins);
    return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
  endfunction

  // x1 (ra) and x5 (t0) are the conventional link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  function automatic dec_t decode(input logic [31:0] ins);
    dec_t d;
    d.is_br   = (ins[6:0] == OPC_BRANCH);
    d.is_jal  = (ins[6:0] == OPC_JAL);
    d.is_jalr = (ins[6:0] == OPC_JALR);
    d.rd      = ins[11:7];
    d.rs1     = ins[19:15];
    return d;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side and commit-side signal bundle of the gshare predictor.
// Prediction outputs are combinational from the fetch fields (zero cycles).
// rdy is a global stall: low freezes all predictor state.
// Ports: rdy, fetch_valid/pc_cur/ins in; pc_next/is_jump/pred_ghr out;
//        commit_valid/commit_pc/commit_ghr/commit_taken/commit_mispredict in.
interface gshare_predictor_if #(
  parameter int GHR_W = 8
);
  logic             rdy;
  logic             fetch_valid;
  logic [31:0]      pc_cur;
  logic [31:0]      ins;
  logic [31:0]      pc_next;
  logic             is_jump;
  logic [GHR_W-1:0] pred_ghr;
  logic             commit_valid;
  logic [31:0]      commit_pc;
  logic [GHR_W-1:0] commit_ghr;
  logic             commit_taken;
  logic             commit_mispredict;

  // master: fetch stage + ROB side
  modport master (
    output rdy, fetch_valid, pc_cur, ins,
    output commit_valid, commit_pc, commit_ghr, commit_taken, commit_mispredict,
    input  pc_next, is_jump, pred_ghr
  );

  // slave: the predictor
  modport slave (
    input  rdy, fetch_valid, pc_cur, ins,
    input  commit_valid, commit_pc, commit_ghr, commit_taken, commit_mispredict,
    output pc_next, is_jump, pred_ghr
  );
endinterface

// File: rtl/gshare_predictor_ras.sv
// pred_ras: circular return-address stack with push, pop, push+pop replace and flush.
// top/empty are combinational from state; updates land on the next clk edge.
// en low holds all state; a full push overwrites the oldest entry.
// Ports: clk, rst_n (sync, active-low), en, flush, push, pop, push_addr in; top, empty out.
module pred_ras #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] push_addr,
  output logic [31:0] top,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] ptr;      // next slot to write
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;  // slot holding the current top

  assign ptr_inc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  assign ptr_dec = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
  assign top     = mem[ptr_dec];
  assign empty   = (cnt == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
    end else if (en) begin
      if (flush) begin
        cnt <= '0;
      end else if (push && pop && !empty) begin
        // call-through-return: swap the top in place
        mem[ptr_dec] <= push_addr;
      end else if (push) begin
        mem[ptr] <= push_addr;
        ptr      <= ptr_inc;
        if (cnt != CNT_W'(DEPTH)) cnt <= cnt + CNT_W'(1);
      end else if (pop && !empty) begin
        ptr <= ptr_dec;
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: next-PC / taken prediction, table indexed by PC ^ speculative GHR.
// Zero-cycle prediction (combinational from pc_cur/ins); training and GHR update on clk.
// rdy low freezes table, GHR and RAS; outputs keep following the inputs.
// Ports: clk, rst_n (sync, active-low), bus (gshare_predictor_if.slave).
// Optional: define PRED_RAS_EN to compile in a RAS_DEPTH-entry return address stack.
module gshare_predictor
  import gshare_predictor_pkg::*;
#(
  parameter int IDX_W     = 8,
  parameter int GHR_W     = 8,
  parameter int CTR_W     = 2,
  parameter int CTR_INIT  = 1,
  parameter int RAS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  gshare_predictor_if.slave   bus
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [CTR_W-1:0] ctr [ENTRIES];
  logic [GHR_W-1:0] ghr;

  dec_t             dec;
  logic [IDX_W-1:0] pidx;
  logic [IDX_W-1:0] cidx;
  logic [CTR_W-1:0] ccur;
  logic [CTR_W-1:0] cupd;
  logic [31:0]      pc_seq;
  logic             br_taken;
  logic [31:0]      pc_next;
  logic             is_jump;
  logic [GHR_W:0]   spec_hist;
  logic [GHR_W:0]   repair_hist;
  logic             unused_commit_pc;

  assign dec      = decode(bus.ins);
  assign pc_seq   = bus.pc_cur + 32'd4;
  assign pidx     = bus.pc_cur[IDX_W+1:2] ^ IDX_W'(ghr);
  assign br_taken = dec.is_br && ctr[pidx][CTR_W-1];

  // Only the word-index bits of the commit PC select a counter.
  assign unused_commit_pc = ^{bus.commit_pc[31:IDX_W+2], bus.commit_pc[1:0]};

`ifdef PRED_RAS_EN
  logic        ras_push;
  logic        ras_pop;
  logic        ras_empty;
  logic [31:0] ras_top;

  assign ras_push = (dec.is_jal || dec.is_jalr) && is_link(dec.rd);
  // Return: rs1 is a link and rd is x0, or rd is the other link register
  // (coroutine swap, which both pops and pushes).
  assign ras_pop  = dec.is_jalr && is_link(dec.rs1) &&
                    ((dec.rd == 5'd0) || (is_link(dec.rd) && (dec.rd != dec.rs1)));

  pred_ras #(
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (bus.rdy),
    .flush     (bus.commit_valid && bus.commit_mispredict),
    .push      (bus.fetch_valid && ras_push),
    .pop       (bus.fetch_valid && ras_pop),
    .push_addr (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`else
  logic unused_ras_fields;
  assign unused_ras_fields = ^{dec.rd, dec.rs1, dec.is_jalr};
`endif

  always_comb begin
    pc_next = pc_seq;
    is_jump = 1'b0;
    if (dec.is_jal) begin
      pc_next = bus.pc_cur + j_imm(bus.ins);
      is_jump = 1'b1;
    end else if (br_taken) begin
      pc_next = bus.pc_cur + b_imm(bus.ins);
      is_jump = 1'b1;
    end
`ifdef PRED_RAS_EN
    else if (ras_pop && !ras_empty) begin
      pc_next = ras_top;
      is_jump = 1'b1;
    end
`endif
  end

  assign bus.pc_next  = pc_next;
  assign bus.is_jump  = is_jump;
  assign bus.pred_ghr = ghr;

  // Commit-time counter update (saturating both ways).
  assign cidx = bus.commit_pc[IDX_W+1:2] ^ IDX_W'(bus.commit_ghr);
  assign ccur = ctr[cidx];
  always_comb begin
    cupd = ccur;
    if (bus.commit_taken) begin
      if (ccur != {CTR_W{1'b1}}) cupd = ccur + CTR_W'(1);
    end else begin
      if (ccur != '0) cupd = ccur - CTR_W'(1);
    end
  end

  // Wide concatenations keep the shift legal even for GHR_W == 1.
  assign spec_hist   = {ghr, br_taken};
  assign repair_hist = {bus.commit_ghr, bus.commit_taken};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_W'(CTR_INIT);
      ghr <= '0;
    end else if (bus.rdy) begin
      // Write lands this edge; a same-index prediction this cycle saw the old value.
      if (bus.commit_valid) ctr[cidx] <= cupd;
      // Repair wins over the speculative shift.
      if (bus.commit_valid && bus.commit_mispredict)
        ghr <= repair_hist[GHR_W-1:0];
      else if (bus.fetch_valid && dec.is_br)
        ghr <= spec_hist[GHR_W-1:0];
    end
  end

endmodule
